// File: rtl/sd_multiblock_cache.sv
// sd_multiblock_cache: MMIO front end with NBUF 512-byte sector buffers in
// front of an SPI-mode byte-stream SD controller. Software loads, flushes or
// write-back-and-reloads a buffer by command; a small FSM streams the bytes.
// Optional build macro SDC_IRQ_EN adds a completion interrupt with enable and
// pending-clear register at 0x2020; without it irq is tied low.
module sd_multiblock_cache #(
  parameter int NBUF  = 4,
  parameter int WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  input  logic        sd_ncd,
  output logic [31:0] ctl_address,
  output logic        ctl_rd,
  output logic        ctl_wr,
  input  logic [7:0]  ctl_dout,
  input  logic        ctl_byte_available,
  output logic [7:0]  ctl_din,
  input  logic        ctl_ready_for_next_byte,
  input  logic        ctl_ready
);

  localparam int BW  = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int NB2 = 2 ** BW;
  localparam int WW  = $clog2(WORDS);
  localparam logic [4:0] NBUF_L = 5'(NBUF);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_FLUSH = 2'b10;
  localparam logic [1:0] OP_LDWB  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_DATA, WB_WAIT, RD_REQ, RD_DATA, RD_WAIT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     t_q, t_d;
  logic [31:0]       s_q, s_d;
  logic [1:0]        op_q, op_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [7:0]        din_q, din_d;
  logic [23:0]       word_q, word_d;

  logic [31:0]       addr_q;
  logic [BW-1:0]     sel_q;
  logic [31:0]       tag_q [NB2];
  logic [NB2-1:0]    valid_q, dirty_q;
  logic              err_q;

  logic              ba_p0, ba_p1, rn_p0, rn_p1, rdy_p0, rdy_p1;
  logic              ba_rise, rn_rise, rdy_rise;

  logic [31:0]       mem [NB2*WORDS];

  logic              busy;
  logic              wr_win, wr_addr, wr_cmd, wr_sel, wr_stat;
  logic              win_drop, win_ok, sel_ok;
  logic [1:0]        cmd_op;
  logic [BW-1:0]     cmd_idx;
  logic              cmd_idx_ok, cmd_acc, cmd_err, set_err;
  logic              eng_wr, wb_done, rd_done;
  logic [31:0]       eng_rword;
  logic [7:0]        eng_rbyte;

  assign busy = (state_q != IDLE) && (state_q != DONE);

  // Bus decode. A window write to the buffer the engine owns is dropped.
  assign wr_win     = we && (a[15:9] == 7'd0);
  assign wr_addr    = we && (a == 16'h1000);
  assign wr_cmd     = we && (a == 16'h1004);
  assign wr_sel     = we && (a == 16'h1008);
  assign wr_stat    = we && (a == 16'h2010);
  assign win_drop   = wr_win && busy && (sel_q == t_q);
  assign win_ok     = wr_win && !win_drop;
  assign sel_ok     = d < 32'(NBUF);
  assign cmd_op     = d[1:0];
  assign cmd_idx    = d[8 +: BW];
  assign cmd_idx_ok = {1'b0, d[11:8]} < NBUF_L;
  assign cmd_acc    = wr_cmd && (cmd_op != 2'b00) && cmd_idx_ok &&
                      (state_q == IDLE) && ctl_ready && !sd_ncd;
  assign cmd_err    = wr_cmd && !cmd_acc && (!cmd_idx_ok || (cmd_op != 2'b00));
  assign set_err    = cmd_err || win_drop || (wr_sel && !sel_ok);

  assign ba_rise  = ba_p0  & ~ba_p1;
  assign rn_rise  = rn_p0  & ~rn_p1;
  assign rdy_rise = rdy_p0 & ~rdy_p1;

  assign eng_rword = mem[{t_q, cnt_q[WW+1:2]}];

  // Pick the outgoing byte; card byte 4k+j sits at bits [31-8j -: 8].
  always_comb begin
    eng_rbyte = eng_rword[31:24];
    case (cnt_q[1:0])
      2'd1:    eng_rbyte = eng_rword[23:16];
      2'd2:    eng_rbyte = eng_rword[15:8];
      2'd3:    eng_rbyte = eng_rword[7:0];
      default: eng_rbyte = eng_rword[31:24];
    endcase
  end

  // Controller handshake outputs follow the engine state.
  assign ctl_wr      = (state_q == WB_REQ);
  assign ctl_rd      = (state_q == RD_REQ);
  assign ctl_din     = din_q;
  assign ctl_address = (state_q == WB_REQ || state_q == WB_DATA || state_q == WB_WAIT) ? tag_q[t_q] :
                       (state_q == RD_REQ || state_q == RD_DATA || state_q == RD_WAIT) ? s_q : 32'd0;

  // Sample the slow-clock strobes one flop deep for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ba_p0 <= 1'b0; ba_p1 <= 1'b0;
      rn_p0 <= 1'b0; rn_p1 <= 1'b0;
      rdy_p0 <= 1'b0; rdy_p1 <= 1'b0;
    end else begin
      ba_p0 <= ctl_byte_available;      ba_p1 <= ba_p0;
      rn_p0 <= ctl_ready_for_next_byte; rn_p1 <= rn_p0;
      rdy_p0 <= ctl_ready;              rdy_p1 <= rdy_p0;
    end
  end

  // Engine next-state and transfer datapath.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    word_d  = word_q;
    eng_wr  = 1'b0;
    wb_done = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          t_d  = cmd_idx;
          s_d  = addr_q;
          op_d = cmd_op;
          case (cmd_op)
            OP_FLUSH: state_d = dirty_q[cmd_idx] ? WB_REQ : DONE;
            OP_LOAD:  state_d = RD_REQ;
            default:  state_d = (valid_q[cmd_idx] && dirty_q[cmd_idx]) ? WB_REQ : RD_REQ;
          endcase
        end
      end
      WB_REQ: begin
        if (!ctl_ready) begin
          cnt_d   = 10'd0;
          state_d = WB_DATA;
        end
      end
      WB_DATA: begin
        if (rn_rise) begin
          din_d = eng_rbyte;
          cnt_d = cnt_q + 10'd1;
          if (cnt_q == 10'd511) state_d = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (rdy_rise) begin
          wb_done = 1'b1;
          state_d = (op_q == OP_LDWB) ? RD_REQ : DONE;
        end
      end
      RD_REQ: begin
        if (!ctl_ready) begin
          cnt_d   = 10'd0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (ba_rise) begin
          word_d = {word_q[15:0], ctl_dout};
          eng_wr = (cnt_q[1:0] == 2'd3);
          cnt_d  = cnt_q + 10'd1;
          if (cnt_q == 10'd511) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rdy_rise) begin
          rd_done = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine control state and outgoing byte register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
    end
  end

  // Transfer bookkeeping; only meaningful while the engine is active.
  always_ff @(posedge clk) begin
    t_q    <= t_d;
    s_q    <= s_d;
    op_q   <= op_d;
    cnt_q  <= cnt_d;
    word_q <= word_d;
  end

  // Buffer storage: bus and engine never target the same buffer in one cycle.
  always_ff @(posedge clk) begin
    if (win_ok) mem[{sel_q, a[WW+1:2]}] <= d;
    if (eng_wr) mem[{t_q, cnt_q[WW+1:2]}] <= {word_q, ctl_dout};
  end

  // Software-visible registers and per-buffer tag/valid/dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'd0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int n = 0; n < NB2; n++) tag_q[n] <= 32'hFFFF_FFFF;
    end else begin
      if (wr_addr) addr_q <= d;
      if (wr_sel && sel_ok) sel_q <= d[BW-1:0];
      if (set_err) err_q <= 1'b1;
      else if (wr_stat && d[1]) err_q <= 1'b0;
      if (wb_done) dirty_q[t_q] <= 1'b0;
      if (rd_done) begin
        tag_q[t_q]   <= s_q;
        valid_q[t_q] <= 1'b1;
        dirty_q[t_q] <= 1'b0;
      end
      if (win_ok) dirty_q[sel_q] <= 1'b1;
    end
  end

`ifdef SDC_IRQ_EN
  logic irq_en_q, irq_pend_q;
  logic wr_irq;
  assign wr_irq = we && (a == 16'h2020);
  assign irq    = irq_pend_q & irq_en_q;

  // Completion interrupt: pending set in DONE, cleared by software.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      if (wr_irq) irq_en_q <= d[0];
      if (state_q == DONE) irq_pend_q <= 1'b1;
      else if (wr_irq && d[1]) irq_pend_q <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // MMIO read mux, combinational from the address.
  always_comb begin
    spo = 32'd0;
    if (a[15:9] == 7'd0) begin
      spo = mem[{sel_q, a[WW+1:2]}];
    end else if (a[15:6] == 10'h044) begin
      for (int n = 0; n < NBUF; n++)
        if (a[5:2] == 4'(n)) spo = tag_q[n];
    end else begin
      case (a)
        16'h1000: spo = addr_q;
        16'h1008: spo = 32'(sel_q);
        16'h2000: spo = {31'd0, sd_ncd};
        16'h2010: spo = {30'd0, err_q, busy};
        16'h2014: spo = 32'(dirty_q);
        16'h2018: spo = 32'(valid_q);
`ifdef SDC_IRQ_EN
        16'h2020: spo = {31'd0, irq_en_q};
`endif
        default:  spo = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_multiblock_cache.sv
// Directed bench for sd_multiblock_cache with a byte-level SD controller model.
module tb_sd_multiblock_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        irq;
  logic        sd_ncd;
  logic [31:0] ctl_address;
  logic        ctl_rd, ctl_wr;
  logic [7:0]  ctl_dout, ctl_din;
  logic        ctl_byte_available, ctl_ready_for_next_byte, ctl_ready;

  int nvec = 0;
  int nmis = 0;

  logic [7:0]  cap [512];
  logic [31:0] wr_addr_seen, rd_addr_seen;
  logic [31:0] v;
  logic        irq_exp;

  sd_multiblock_cache #(.NBUF(4), .WORDS(128)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
    .sd_ncd(sd_ncd), .ctl_address(ctl_address), .ctl_rd(ctl_rd), .ctl_wr(ctl_wr),
    .ctl_dout(ctl_dout), .ctl_byte_available(ctl_byte_available), .ctl_din(ctl_din),
    .ctl_ready_for_next_byte(ctl_ready_for_next_byte), .ctl_ready(ctl_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bw(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    a = addr; d = data; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic br(input logic [15:0] addr, output logic [31:0] val);
    @(negedge clk);
    a = addr;
    #1 val = spo;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    br(addr, r);
    chk(tag, r, exp);
  endtask

  // Poll status until busy drops; returns during the DONE cycle.
  task automatic wait_idle();
    int k;
    k = 0;
    a = 16'h2010;
    do begin
      @(negedge clk);
      a = 16'h2010;
      #1;
      k++;
    end while (spo[0] === 1'b1 && k < 6000);
    if (k >= 6000) chk("idle_timeout", {31'd0, spo[0]}, 32'd0);
  endtask

  // Controller model, read side: serves 512 bytes (i + seed).
  task automatic model_rd(input logic [7:0] seed);
    int k;
    k = 0;
    while (ctl_rd !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    if (ctl_rd !== 1'b1) begin chk("rd_req", {31'd0, ctl_rd}, 32'd1); return; end
    rd_addr_seen = ctl_address;
    ctl_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      ctl_dout = 8'(i) + seed;
      ctl_byte_available = 1'b1;
      repeat (3) @(negedge clk);
      ctl_byte_available = 1'b0;
      repeat (2) @(negedge clk);
    end
    ctl_ready = 1'b1;
  endtask

  // Controller model, write side: captures 512 bytes into cap[].
  task automatic model_wr();
    int k;
    k = 0;
    while (ctl_wr !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    if (ctl_wr !== 1'b1) begin chk("wr_req", {31'd0, ctl_wr}, 32'd1); return; end
    wr_addr_seen = ctl_address;
    ctl_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      ctl_ready_for_next_byte = 1'b1;
      repeat (3) @(negedge clk);
      cap[i] = ctl_din;
      ctl_ready_for_next_byte = 1'b0;
      repeat (2) @(negedge clk);
    end
    ctl_ready = 1'b1;
  endtask

  initial begin
`ifdef SDC_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    rst = 1'b1; a = 16'h0; d = 32'h0; we = 1'b0; sd_ncd = 1'b0;
    ctl_dout = 8'h0; ctl_byte_available = 1'b0;
    ctl_ready_for_next_byte = 1'b0; ctl_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_ctl", {28'd0, ctl_rd, ctl_wr, irq, 1'b0}, 32'd0);
    chk("rst_din", {24'd0, ctl_din}, 32'd0);
    chk("rst_caddr", ctl_address, 32'd0);
    rdchk("rst_status", 16'h2010, 32'd0);
    rdchk("rst_valid", 16'h2018, 32'd0);
    rdchk("rst_dirty", 16'h2014, 32'd0);
    rdchk("rst_tag0", 16'h1100, 32'hFFFF_FFFF);
    rdchk("rst_tag3", 16'h110C, 32'hFFFF_FFFF);
    rdchk("rst_addr", 16'h1000, 32'd0);
    rdchk("unmapped", 16'h3000, 32'd0);

    // LOAD buffer 0 from sector 0x10
    bw(16'h1000, 32'h10);
    fork
      model_rd(8'h00);
      begin
        bw(16'h1004, 32'h0001);
        rdchk("ld0_busy", 16'h2010, 32'd1);
        wait_idle();
      end
    join
    chk("ld0_addr", rd_addr_seen, 32'h10);
    rdchk("ld0_w0", 16'h0000, 32'h0001_0203);
    rdchk("ld0_w127", 16'h01FC, 32'hFCFD_FEFF);
    rdchk("ld0_tag", 16'h1100, 32'h10);
    rdchk("ld0_valid", 16'h2018, 32'h1);
    rdchk("ld0_dirty", 16'h2014, 32'h0);

    // Dirty word 1 of buffer 0 then FLUSH
    bw(16'h0004, 32'hDEAD_BEEF);
    rdchk("fl_dirty_set", 16'h2014, 32'h1);
    fork
      model_wr();
      begin
        bw(16'h1004, 32'h0002);
        wait_idle();
      end
    join
    chk("fl_addr", wr_addr_seen, 32'h10);
    chk("fl_b0_3", {cap[0], cap[1], cap[2], cap[3]}, 32'h0001_0203);
    chk("fl_b4_7", {cap[4], cap[5], cap[6], cap[7]}, 32'hDEAD_BEEF);
    chk("fl_b511", {24'd0, cap[511]}, 32'hFF);
    rdchk("fl_dirty", 16'h2014, 32'h0);

    // LOAD buffer 1 from 0x20, dirty it, then LOAD_WB from 0x30
    bw(16'h1000, 32'h20);
    fork
      model_rd(8'h40);
      begin
        bw(16'h1004, 32'h0101);
        wait_idle();
      end
    join
    rdchk("ld1_tag", 16'h1104, 32'h20);
    bw(16'h1008, 32'd1);
    bw(16'h0000, 32'h1122_3344);
    rdchk("ld1_dirty", 16'h2014, 32'h2);
    bw(16'h1000, 32'h30);
    fork
      begin
        model_wr();
        model_rd(8'h80);
      end
      begin
        bw(16'h1004, 32'h0103);
        wait_idle();
      end
    join
    chk("lwb_waddr", wr_addr_seen, 32'h20);
    chk("lwb_wb0", {cap[0], cap[1], cap[2], cap[3]}, 32'h1122_3344);
    chk("lwb_wb1", {cap[4], cap[5], cap[6], cap[7]}, 32'h4445_4647);
    chk("lwb_raddr", rd_addr_seen, 32'h30);
    rdchk("lwb_tag1", 16'h1104, 32'h30);
    rdchk("lwb_valid", 16'h2018, 32'h3);
    rdchk("lwb_dirty", 16'h2014, 32'h0);
    rdchk("lwb_w0", 16'h0000, 32'h8081_8283);

    // Bus traffic during a LOAD into buffer 2
    bw(16'h1000, 32'h50);
    fork
      model_rd(8'hC0);
      begin
        bw(16'h1004, 32'h0201);
        bw(16'h1008, 32'd2);
        bw(16'h1004, 32'h0002);
        rdchk("busy_cmd_err", 16'h2010, 32'h3);
        bw(16'h2010, 32'h2);
        rdchk("err_clr", 16'h2010, 32'h1);
        bw(16'h0000, 32'h1234_5678);
        rdchk("busy_win_err", 16'h2010, 32'h3);
        bw(16'h1008, 32'd0);
        bw(16'h0008, 32'hCAFE_F00D);
        rdchk("busy_win_dirty", 16'h2014, 32'h1);
        wait_idle();
      end
    join
    rdchk("ld2_tag", 16'h1108, 32'h50);
    rdchk("ld2_valid", 16'h2018, 32'h7);
    rdchk("ld2_dirty", 16'h2014, 32'h1);
    rdchk("b0_w2", 16'h0008, 32'hCAFE_F00D);
    rdchk("b0_w0", 16'h0000, 32'h0001_0203);
    bw(16'h1008, 32'd2);
    rdchk("ld2_w0", 16'h0000, 32'hC0C1_C2C3);
    rdchk("ld2_err", 16'h2010, 32'h2);
    bw(16'h2010, 32'h2);

    // Out-of-range indices
    bw(16'h1008, 32'd5);
    rdchk("sel_bad_keep", 16'h1008, 32'd2);
    rdchk("sel_bad_err", 16'h2010, 32'h2);
    bw(16'h2010, 32'h2);
    bw(16'h1004, 32'h0401);
    rdchk("cmd_bad_err", 16'h2010, 32'h2);
    chk("cmd_bad_rd", {31'd0, ctl_rd}, 32'd0);
    bw(16'h2010, 32'h2);

    // Card removed at command accept
    sd_ncd = 1'b1;
    rdchk("ncd_read", 16'h2000, 32'h1);
    bw(16'h1004, 32'h0001);
    repeat (2) @(negedge clk);
    chk("ncd_rd", {31'd0, ctl_rd}, 32'd0);
    rdchk("ncd_err", 16'h2010, 32'h2);
    bw(16'h2010, 32'h2);
    sd_ncd = 1'b0;

    // Reset in the middle of a read transfer
    bw(16'h1000, 32'h60);
    bw(16'h1004, 32'h0301);
    chk("mid_rd_req", {31'd0, ctl_rd}, 32'd1);
    ctl_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      ctl_dout = 8'(i); ctl_byte_available = 1'b1;
      repeat (3) @(negedge clk);
      ctl_byte_available = 1'b0;
      repeat (2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst_rd", {31'd0, ctl_rd}, 32'd0);
    ctl_ready = 1'b1;
    rdchk("mrst_status", 16'h2010, 32'd0);
    rdchk("mrst_valid", 16'h2018, 32'd0);
    rdchk("mrst_tag3", 16'h110C, 32'hFFFF_FFFF);

    // Fresh LOAD after reset, with completion interrupt enabled
    bw(16'h2020, 32'h1);
    rdchk("irq_en_rd", 16'h2020, {31'd0, irq_exp});
    bw(16'h1000, 32'h70);
    fork
      model_rd(8'h33);
      begin
        bw(16'h1004, 32'h0301);
        wait_idle();
        chk("irq_done_cyc", {31'd0, irq}, 32'd0);
        @(negedge clk);
        #1 chk("irq_after", {31'd0, irq}, {31'd0, irq_exp});
      end
    join
    bw(16'h2020, 32'h3);
    #1 chk("irq_clr", {31'd0, irq}, 32'd0);
    rdchk("ld3_tag", 16'h110C, 32'h70);
    rdchk("ld3_valid", 16'h2018, 32'h8);
    bw(16'h1008, 32'd3);
    rdchk("ld3_w0", 16'h0000, 32'h3334_3536);
    rdchk("ld3_w127", 16'h01FC, 32'h2F30_3132);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sd_multiblock_cache.md
Name: sd_multiblock_cache

Overview:
Memory-mapped SD card front end holding NBUF independent 512-byte block buffers. Each buffer has its own sector tag, valid bit and dirty bit. Software loads and flushes buffers by command; an optional combined command writes back a dirty buffer and then reloads it in one operation. The block sits on the CPU MMIO bus and drives an external SPI-mode byte-stream SD controller, which produces sclk/cs/mosi and paces bytes on its own slow clock.

Parameters:
NBUF, 4, number of block buffers; 1..16; index width BW = max(1, clog2(NBUF)).
WORDS, 128, 32-bit words per buffer; fixed 512-byte sector, not to be changed.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
a  in  16  MMIO byte address (word aligned)
d  in  32  MMIO write data
we  in  1  MMIO write strobe, one cycle per write
spo  out  32  MMIO read data, combinational from a
irq  out  1  completion interrupt, level (see Optional Feature)
sd_ncd  in  1  card-detect, active low
ctl_address  out  32  sector address to controller
ctl_rd  out  1  read-sector request
ctl_wr  out  1  write-sector request
ctl_dout  in  8  read byte from controller
ctl_byte_available  in  1  read byte strobe, slow-clock level
ctl_din  out  8  write byte to controller
ctl_ready_for_next_byte  in  1  write byte request, slow-clock level
ctl_ready  in  1  controller idle

Behaviour:
- Map:
  - 0x0000-0x01FC R/W: word a[8:2] of buffer SEL.
  - 0x1000 R/W: ADDR.
  - 0x1004 W: CMD. d[1:0] is op: 01 LOAD, 10 FLUSH, 11 LOAD_WB, 00 no-op. d[11:8] is target buffer index.
  - 0x1008 R/W: SEL.
  - 0x1100+4n R: TAG[n].
  - 0x2000 R: sd_ncd.
  - 0x2010 R: {30'b0, err, busy}.
  - 0x2014 R: dirty bitmap.
  - 0x2018 R: valid bitmap.
  - Unmapped addresses read 0.
- Reset values: spo follows a; irq=0, ctl_rd=0, ctl_wr=0, ctl_din=0, ctl_address=0; ADDR=0, SEL=0, TAG[n]=0xFFFFFFFF; valid, dirty, err, busy all 0; FSM=IDLE. Buffer contents are undefined after reset.
- Index handling: an index >= NBUF in CMD or SEL is not accepted. The register or command is ignored and err=1.
- Byte order: card byte 4k+j maps to word k, bits [31-8j -: 8]. Bus words are stored unswapped.
- Edge detection: byte_available, ready_for_next_byte and ready are each sampled through a 1-flop delay. Rising edges are detected in the clk domain.
- FSM states: IDLE, WB_REQ, WB_DATA, WB_WAIT, RD_REQ, RD_DATA, RD_WAIT, DONE.
- Command accept: a CMD write in IDLE with ctl_ready=1 latches target T and sector S=ADDR; busy=1 from the next cycle.
  - FLUSH goes to WB_REQ using TAG[T]. If buffer T is not dirty, go straight to DONE.
  - LOAD goes to RD_REQ.
  - LOAD_WB goes to WB_REQ if T is both valid and dirty, else to RD_REQ.
- WB_REQ: ctl_address=TAG[T], ctl_wr=1, held until ctl_ready=0. Then drop ctl_wr, clear the byte counter (10 bits), go to WB_DATA.
- WB_DATA: on each ready_for_next_byte rising edge, drive ctl_din with byte[counter] of buffer T and increment the counter. After 512 bytes go to WB_WAIT. On ctl_ready rising edge, clear dirty[T]; then go to RD_REQ for LOAD_WB, or DONE for FLUSH.
- RD_REQ/RD_DATA/RD_WAIT: mirror of the write path using ctl_rd and ctl_address=S. Bytes are assembled into words; each full word is written on its 4th byte. On ctl_ready rising edge after 512 bytes: TAG[T]=S, valid[T]=1, dirty[T]=0, then DONE.
- DONE: one cycle; busy=0 and irq_pend=1, then IDLE.
- Bus writes during an operation:
  - A CMD write while busy is ignored and sets err=1.
  - A data-window write while busy and SEL==T is dropped and sets err=1.
  - A data-window write to any other buffer is performed and sets that buffer's dirty bit.
- A data-window write in IDLE sets dirty[SEL]=1.
- Simultaneous events: an engine word write has priority over a bus write only when both target the same buffer, and that case is already dropped.
- err: sticky; cleared by writing 1 to 0x2010 bit1.
- A card removed (sd_ncd=1) at command accept aborts the command: err=1, no request is issued.

Optional Feature:
SDC_IRQ_EN.
- Defined: irq = irq_pend & irq_en. 0x2020 R/W: bit0 is irq_en (reset 0). Writing 0x2020 with d[1]=1 clears irq_pend.
- Undefined: irq is tied 0, 0x2020 reads 0 and ignores writes, and no irq_pend register exists.

Test Plan:
- ADDR=0x10, CMD=0x0001 (LOAD buf0); model sends bytes 0x00..0xFF twice -> busy 1 then 0; word 0 = 0x00010203; TAG[0]=0x10; valid=0x1; dirty=0.
- Write 0xDEADBEEF at 0x0004 with SEL=0, then CMD=0x0002 (FLUSH) -> model receives bytes 4..7 = DE AD BE EF for sector 0x10; dirty=0.
- Dirty buf1 (TAG 0x20), ADDR=0x30, CMD=0x0103 (LOAD_WB) -> write of sector 0x20 first, then read of 0x30; TAG[1]=0x30.
- During a LOAD into buf2: issue CMD and a window write with SEL=2 -> both are ignored and err=1; a window write with SEL=0 succeeds and sets dirty bit0.
- Assert rst mid-RD_DATA -> next cycle ctl_rd=0, busy=0, valid=0, FSM=IDLE; a new LOAD then completes normally.
- SDC_IRQ_EN defined, irq_en=1 -> irq rises one cycle after busy falls; writing 0x2020 with d=0x3 clears it.
